// File: rtl/ac_setpoint_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ac_setpoint_driver
//  Description : Initiator side of the AC increase/decrease command link.
//                Steps the AC one code at a time toward a latched target.
//                A command the AC does not answer is retried, and a sticky
//                fault is raised once the retries are used up.
//  Revision    : 1.0  initial release
// ============================================================================
module ac_setpoint_driver #(
    parameter int TEMP_NBITS     = 3,
    parameter int PULSE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 6,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [TEMP_NBITS-1:0] setpoint,
    input  logic                  setpoint_load,
    input  logic [TEMP_NBITS-1:0] actual_temp,
    input  logic                  dripping,
    output logic                  increase,
    output logic                  decrease,
    output logic                  busy,
    output logic                  at_target,
    output logic                  fault
);

    // The timer counts down from N-1 to 0, so it only has to hold max-1.
    localparam int c_TIMER_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int c_TW        = (c_TIMER_MAX > 1) ? $clog2(c_TIMER_MAX) : 1;
    localparam int c_RW        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [c_TW-1:0] c_PULSE_LAST   = c_TW'(PULSE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_RW-1:0] c_RETRY_LIMIT  = c_RW'(MAX_RETRIES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                r_state;
    logic [TEMP_NBITS-1:0] r_target;
    logic [TEMP_NBITS-1:0] r_prev;
    logic [c_TW-1:0]       r_timer;
    logic [c_RW-1:0]       r_retries;
    logic                  r_dir;
    logic                  r_at_target;

    // Command sequencer: issue a pulse, wait for the AC to move, retry or fault.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_prev      <= '0;
            r_timer     <= '0;
            r_retries   <= '0;
            r_dir       <= 1'b0;
            r_at_target <= 1'b0;
        end else begin
            // A new setpoint never aborts a command already in flight; it is
            // acted on at the next IDLE decision.
            if (setpoint_load) begin
                r_target <= setpoint;
            end

            r_at_target <= (r_state == S_IDLE) && (r_target == actual_temp);

            case (r_state)
                S_IDLE: begin
                    r_retries <= '0;
                    if ((r_target != actual_temp) && !dripping) begin
                        r_dir   <= (r_target > actual_temp);
                        r_timer <= c_PULSE_LAST;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (r_timer == '0) begin
                        // Snapshot the reading so any later movement counts as an answer.
                        r_prev  <= actual_temp;
                        r_timer <= c_TIMEOUT_LAST;
                        r_state <= S_WAIT;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end

                S_WAIT: begin
                    if (actual_temp != r_prev) begin
                        r_retries <= '0;
                        r_state   <= S_IDLE;
                    end else if ((r_timer == '0) && (r_retries == c_RETRY_LIMIT)) begin
                        r_state <= S_FAULT;
                    end else if (r_timer == '0) begin
                        // Re-issue in the same direction as the unanswered command.
                        r_retries <= r_retries + c_RW'(1);
                        r_timer   <= c_PULSE_LAST;
                        r_state   <= S_ISSUE;
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end

                S_FAULT: begin
                    if (setpoint_load) begin
                        r_retries <= '0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state; no input reaches them.
    assign increase  = (r_state == S_ISSUE) &&  r_dir;
    assign decrease  = (r_state == S_ISSUE) && !r_dir;
    assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign fault     = (r_state == S_FAULT);
    assign at_target = r_at_target;

endmodule
`default_nettype wire
